// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encodings and trace entry layout for the commit trace buffer
package trace_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_POST   = 2'd2;
   localparam logic [1:0] ST_FROZEN = 2'd3;

   localparam int INSTR_W = 32;
   localparam int RADDR_W = 5;

   // Entry packing, MSB to LSB: {ts, pc, instr, rd_we, rd_addr, rd_data}
   function automatic int entry_w(input int xlen, input int ts_w);
      return ts_w + xlen + INSTR_W + 1 + RADDR_W + xlen;
   endfunction

   function automatic int data_lsb(input int xlen);
      return 0 * xlen;
   endfunction

   function automatic int addr_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int we_lsb(input int xlen);
      return xlen + RADDR_W;
   endfunction

   function automatic int instr_lsb(input int xlen);
      return xlen + RADDR_W + 1;
   endfunction

   function automatic int pc_lsb(input int xlen);
      return xlen + RADDR_W + 1 + INSTR_W;
   endfunction

   function automatic int ts_lsb(input int xlen);
      return 2 * xlen + RADDR_W + 1 + INSTR_W;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace storage, one synchronous write port and one registered read port
module trace_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // rdata holds between reads so the top can keep its last response
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retired-instruction trace capture with PC trigger and post-trigger window
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int TS_W  = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cm_valid,
   input  logic [XLEN-1:0] cm_pc,
   input  logic [31:0]     cm_instr,
   input  logic            cm_rd_we,
   input  logic [4:0]      cm_rd_addr,
   input  logic [XLEN-1:0] cm_rd_data,
   input  logic            arm,
   input  logic            stop,
   input  logic            trig_en,
   input  logic [XLEN-1:0] trig_pc,
   input  logic [AW:0]     post_count,
   input  logic            rd_en,
   input  logic [AW-1:0]   rd_idx,
   output logic            rd_valid,
   output logic [TS_W-1:0] rd_ts,
   output logic [XLEN-1:0] rd_pc,
   output logic [31:0]     rd_instr,
   output logic            rd_we,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic [1:0]      state,
   output logic [AW:0]     count,
   output logic            frozen
);

   localparam int          EW       = entry_w(XLEN, TS_W);
   localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   logic [1:0]      state_q;
   logic [AW-1:0]   wptr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     post_q;
   logic [AW:0]     rem_q;
   logic [TS_W-1:0] ts_q;
   logic            rd_valid_q;
   logic            rd_zero_q;

   logic            capturing;
   logic            wr_en;
   logic            trig_hit;
   logic            full;
   logic [AW:0]     post_sat;
   logic            rd_hit;
   logic [AW-1:0]   oldest;
   logic [AW-1:0]   raddr;
   logic [EW-1:0]   wdata;
   logic [EW-1:0]   rdata;

   assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
   // a commit coinciding with arm belongs to the capture being discarded
   assign wr_en     = capturing && cm_valid && !arm;
   assign trig_hit  = (state_q == ST_ARMED) && wr_en && trig_en && (cm_pc == trig_pc);
   assign full      = (count_q == FULL);
   assign post_sat  = (post_count > MAX_POST) ? MAX_POST : post_count;
   assign wdata     = {ts_q, cm_pc, cm_instr, cm_rd_we, cm_rd_addr, cm_rd_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wptr_q  <= '0;
         count_q <= '0;
         post_q  <= '0;
         rem_q   <= '0;
         ts_q    <= '0;
      end else if (arm) begin
         state_q <= ST_ARMED;
         wptr_q  <= '0;
         count_q <= '0;
         post_q  <= post_sat;
         rem_q   <= '0;
         ts_q    <= '0;
      end else begin
         if (capturing) begin
            ts_q <= ts_q + 1'b1;
         end
         if (wr_en) begin
            wptr_q <= wptr_q + 1'b1;
            if (!full) begin
               count_q <= count_q + 1'b1;
            end
         end
         if (capturing && stop) begin
            state_q <= ST_FROZEN;
         end else if (trig_hit) begin
            if (post_q == '0) begin
               state_q <= ST_FROZEN;
            end else begin
               state_q <= ST_POST;
               rem_q   <= post_q;
            end
         end else if ((state_q == ST_POST) && wr_en) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == ONE) begin
               state_q <= ST_FROZEN;
            end
         end
      end
   end

   // once the ring has wrapped, the write pointer marks the oldest entry
   assign rd_hit = (state_q == ST_FROZEN) && ({1'b0, rd_idx} < count_q);
   assign oldest = full ? wptr_q : '0;
   assign raddr  = oldest + rd_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_zero_q  <= 1'b1;
      end else begin
         rd_valid_q <= rd_en && rd_hit;
         if (rd_en) begin
            rd_zero_q <= !rd_hit;
         end
      end
   end

   trace_ram #(
      .W     (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wptr_q),
      .wdata (wdata),
      .re    (rd_en && rd_hit),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign rd_valid = rd_valid_q;
   assign rd_ts    = rd_zero_q ? '0 : rdata[ts_lsb(XLEN)    +: TS_W];
   assign rd_pc    = rd_zero_q ? '0 : rdata[pc_lsb(XLEN)    +: XLEN];
   assign rd_instr = rd_zero_q ? '0 : rdata[instr_lsb(XLEN) +: INSTR_W];
   assign rd_we    = rd_zero_q ? 1'b0 : rdata[we_lsb(XLEN)];
   assign rd_addr  = rd_zero_q ? '0 : rdata[addr_lsb(XLEN)  +: RADDR_W];
   assign rd_data  = rd_zero_q ? '0 : rdata[data_lsb(XLEN)  +: XLEN];

   assign state  = state_q;
   assign count  = count_q;
   assign frozen = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cm_valid = 1'b0;
   logic [31:0] cm_pc = '0;
   logic [31:0] cm_instr = '0;
   logic        cm_rd_we = 1'b0;
   logic [4:0]  cm_rd_addr = '0;
   logic [31:0] cm_rd_data = '0;
   logic        arm = 1'b0;
   logic        stop = 1'b0;
   logic        trig_en = 1'b0;
   logic [31:0] trig_pc = '0;
   logic [4:0]  post_count = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_idx = '0;
   logic        rd_valid;
   logic [15:0] rd_ts;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic [4:0]  count;
   logic        frozen;

   int tests = 0;
   int fails = 0;

   commit_trace_buffer #(.XLEN(32), .DEPTH(16), .TS_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cm_valid   (cm_valid),
      .cm_pc      (cm_pc),
      .cm_instr   (cm_instr),
      .cm_rd_we   (cm_rd_we),
      .cm_rd_addr (cm_rd_addr),
      .cm_rd_data (cm_rd_data),
      .arm        (arm),
      .stop       (stop),
      .trig_en    (trig_en),
      .trig_pc    (trig_pc),
      .post_count (post_count),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_valid   (rd_valid),
      .rd_ts      (rd_ts),
      .rd_pc      (rd_pc),
      .rd_instr   (rd_instr),
      .rd_we      (rd_we),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .state      (state),
      .count      (count),
      .frozen     (frozen)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [31:0] tpc, input logic ten, input logic [4:0] pcnt);
      trig_pc    = tpc;
      trig_en    = ten;
      post_count = pcnt;
      arm        = 1'b1;
      tick();
      arm        = 1'b0;
   endtask

   task automatic commit(input logic [31:0] pc);
      cm_valid   = 1'b1;
      cm_pc      = pc;
      cm_instr   = pc ^ 32'hA5A5_0013;
      cm_rd_we   = pc[2];
      cm_rd_addr = pc[6:2];
      cm_rd_data = ~pc;
      tick();
      cm_valid   = 1'b0;
   endtask

   task automatic read(input logic [3:0] idx);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en  = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
      tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
      tests++; if (rd_valid !== 1'b0 || frozen !== 1'b0) begin fails++; $display("FAIL reset_flags: rd_valid %b frozen %b want 0 0", rd_valid, frozen); end
      tests++; if ({rd_ts, rd_pc, rd_instr, rd_we, rd_addr, rd_data} !== '0) begin fails++; $display("FAIL reset_fields: pc %h data %h want 0", rd_pc, rd_data); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      do_arm(32'h0, 1'b0, 5'd0);
      tests++; if (state !== 2'd1) begin fails++; $display("FAIL wrap_armed: got %0d want 1", state); end
      for (int k = 0; k < 20; k++) commit(32'(k * 4));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tests++; if (state !== 2'd3 || frozen !== 1'b1) begin fails++; $display("FAIL wrap_frozen: state %0d frozen %b want 3 1", state, frozen); end
      tests++; if (count !== 5'd16) begin fails++; $display("FAIL wrap_count: got %0d want 16", count); end
      read(4'd0);
      tests++; if (rd_valid !== 1'b1 || rd_pc !== 32'h10) begin fails++; $display("FAIL wrap_idx0_pc: valid %b pc %h want 1 00000010", rd_valid, rd_pc); end
      tests++; if (rd_ts !== 16'd4 || rd_instr !== 32'hA5A5_0003) begin fails++; $display("FAIL wrap_idx0_ts_instr: ts %0d instr %h want 4 a5a50003", rd_ts, rd_instr); end
      tests++; if (rd_we !== 1'b0 || rd_addr !== 5'd4 || rd_data !== 32'hFFFF_FFEF) begin fails++; $display("FAIL wrap_idx0_wb: we %b addr %0d data %h want 0 4 ffffffef", rd_we, rd_addr, rd_data); end
      read(4'd15);
      tests++; if (rd_valid !== 1'b1 || rd_pc !== 32'h4C || rd_ts !== 16'd19) begin fails++; $display("FAIL wrap_idx15: valid %b pc %h ts %0d want 1 0000004c 19", rd_valid, rd_pc, rd_ts); end
      tests++; if (rd_we !== 1'b1 || rd_addr !== 5'd19) begin fails++; $display("FAIL wrap_idx15_wb: we %b addr %0d want 1 19", rd_we, rd_addr); end
      tick();
      tests++; if (rd_valid !== 1'b0 || rd_pc !== 32'h4C) begin fails++; $display("FAIL hold: valid %b pc %h want 0 0000004c", rd_valid, rd_pc); end
   endtask

   task automatic test_trigger_post();
      do_arm(32'h20, 1'b1, 5'd3);
      for (int k = 0; k < 17; k++) begin
         commit(32'(k * 4));
         if (k == 10) begin
            tests++; if (state !== 2'd2) begin fails++; $display("FAIL trig_in_post: got %0d want 2", state); end
         end
         if (k == 11) begin
            tests++; if (state !== 2'd3) begin fails++; $display("FAIL trig_frozen_after_2c: got %0d want 3", state); end
         end
      end
      tests++; if (count !== 5'd12) begin fails++; $display("FAIL trig_count: got %0d want 12", count); end
      read(4'd11);
      tests++; if (rd_valid !== 1'b1 || rd_pc !== 32'h2C) begin fails++; $display("FAIL trig_idx11: valid %b pc %h want 1 0000002c", rd_valid, rd_pc); end
      read(4'd12);
      tests++; if (rd_valid !== 1'b0 || rd_pc !== 32'h0) begin fails++; $display("FAIL trig_idx12: valid %b pc %h want 0 0", rd_valid, rd_pc); end
   endtask

   task automatic test_post_zero();
      do_arm(32'h08, 1'b1, 5'd0);
      for (int k = 0; k < 5; k++) commit(32'(k * 4));
      tests++; if (state !== 2'd3) begin fails++; $display("FAIL pz_state: got %0d want 3", state); end
      tests++; if (count !== 5'd3) begin fails++; $display("FAIL pz_count: got %0d want 3", count); end
      read(4'd2);
      tests++; if (rd_valid !== 1'b1 || rd_pc !== 32'h08 || rd_ts !== 16'd2) begin fails++; $display("FAIL pz_idx2: valid %b pc %h ts %0d want 1 00000008 2", rd_valid, rd_pc, rd_ts); end
      read(4'd5);
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL oor_valid: got %b want 0", rd_valid); end
      tests++; if ({rd_ts, rd_pc, rd_instr, rd_we, rd_addr, rd_data} !== '0) begin fails++; $display("FAIL oor_fields: ts %h pc %h instr %h data %h want 0", rd_ts, rd_pc, rd_instr, rd_data); end
   endtask

   task automatic test_arm_stop();
      do_arm(32'h08, 1'b1, 5'd3);
      for (int k = 0; k < 3; k++) commit(32'(k * 4));
      tests++; if (state !== 2'd2) begin fails++; $display("FAIL as_post: got %0d want 2", state); end
      arm  = 1'b1;
      stop = 1'b1;
      tick();
      arm  = 1'b0;
      stop = 1'b0;
      tests++; if (state !== 2'd1 || count !== 5'd0) begin fails++; $display("FAIL as_rearm: state %0d count %0d want 1 0", state, count); end
      read(4'd0);
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL read_not_frozen: got %b want 0", rd_valid); end
   endtask

   task automatic test_rst_mid();
      do_arm(32'h08, 1'b1, 5'd3);
      for (int k = 0; k < 3; k++) commit(32'(k * 4));
      tests++; if (state !== 2'd2) begin fails++; $display("FAIL rm_post: got %0d want 2", state); end
      rd_en  = 1'b1;
      rd_idx = 4'd0;
      #2;
      rst = 1'b1;
      #1;
      tests++; if (state !== 2'd0 || count !== 5'd0 || frozen !== 1'b0) begin fails++; $display("FAIL rm_async: state %0d count %0d frozen %b want 0 0 0", state, count, frozen); end
      tick();
      rd_en = 1'b0;
      rst   = 1'b0;
      tick();
      tick();
      tests++; if (rd_valid !== 1'b0 || state !== 2'd0) begin fails++; $display("FAIL rm_after: valid %b state %0d want 0 0", rd_valid, state); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_trigger_post();
      test_post_zero();
      test_arm_stop();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
